// File: rtl/decoder_seq_ctrl.sv
// Symbol-table scanner: XORs a one-hot code of each table row into an
// accumulator, then latches the accumulator's parity for display.
module decoder_seq_ctrl #(
    parameter int ROWS = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       wr_en,
    input  logic [2:0] wr_addr,
    input  logic [2:0] wr_data,
    input  logic       pb1,
    output logic [7:0] led,
    output logic       busy,
    output logic       done,
    output logic       wr_err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        PARITY = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [2:0] LAST_IDX = 3'(ROWS - 1);

    // Row i lives in bits [3*i +: 3]; rows 0..7 = 3,4,7,2,3,5,0,2.
    localparam logic [23:0] DEFAULT_TBL =
        {3'd2, 3'd0, 3'd5, 3'd3, 3'd2, 3'd7, 3'd4, 3'd3};

    state_t     state_q, state_d;
    logic [7:0] acc_q, acc_d;
    logic       parity_q, parity_d;
    logic [2:0] idx_q, idx_d;
    logic [7:0] led_q, led_d;
    logic       wr_err_q, wr_err_d;
    logic [2:0] tbl_q [8];
    logic [2:0] tbl_d [8];

    logic       writable;

    assign writable = (state_q == IDLE) || (state_q == DONE);

    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path can infer a latch.
        state_d  = state_q;
        acc_d    = acc_q;
        parity_d = parity_q;
        idx_d    = idx_q;
        tbl_d    = tbl_q;
        wr_err_d = 1'b0;
        led_d    = 8'h00;

        if (wr_en) begin
            if (writable) begin
                tbl_d[wr_addr] = wr_data;
            end else begin
                wr_err_d = 1'b1;
            end
        end

        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    acc_d   = 8'h00;
                    idx_d   = 3'd0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                // Symbol v toggles bit (7-v): 0 -> bit 7, 7 -> bit 0.
                acc_d = acc_q ^ (8'h80 >> tbl_q[idx_q]);
                if (idx_q == LAST_IDX) begin
                    state_d = PARITY;
                end else begin
                    idx_d = idx_q + 3'd1;
                end
            end
            PARITY: begin
                parity_d = ^acc_q;
                state_d  = DONE;
            end
            default: state_d = IDLE;
        endcase

        unique case (state_q)
            IDLE:        led_d = 8'h00;
            SCAN, PARITY: led_d = acc_q;
            DONE:        led_d = pb1 ? {7'b0, parity_q} : acc_q;
            default:     led_d = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            acc_q    <= 8'h00;
            parity_q <= 1'b0;
            idx_q    <= 3'd0;
            led_q    <= 8'h00;
            wr_err_q <= 1'b0;
            // NOTE: the table is a small flop array with defined contents, so it is reset like any other state.
            for (int i = 0; i < 8; i++) begin
                tbl_q[i] <= DEFAULT_TBL[i*3 +: 3];
            end
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            state_q  <= state_d;
            acc_q    <= acc_d;
            parity_q <= parity_d;
            idx_q    <= idx_d;
            led_q    <= led_d;
            wr_err_q <= wr_err_d;
            tbl_q    <= tbl_d;
        end
    end

    assign led    = led_q;
    assign busy   = (state_q == SCAN) || (state_q == PARITY);
    assign done   = (state_q == DONE);
    assign wr_err = wr_err_q;

endmodule
